// File: rtl/onewire_slave.sv
// 1-wire responder: answers reset pulses with presence, assembles write slots into bytes
// and returns a loaded byte in read slots. All timing is in units of DVN clocks.
module onewire_slave #(
    parameter int DVN     = 2,
    parameter int DVW     = (DVN > 1) ? $clog2(DVN) : 1,
    parameter int SMP     = 5,
    parameter int RST_MIN = 40,
    parameter int PRS_DLY = 2,
    parameter int PRS_LEN = 16,
    parameter int TX_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire        onewire,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rst_det
);

    typedef enum logic [2:0] {IDLE, LOW, TXD, WAITH, PRSW, PRSD} state_t;

    localparam logic [6:0] U_SMP = 7'(SMP);
    localparam logic [6:0] U_RST = 7'(RST_MIN);
    localparam logic [6:0] U_DLY = 7'(PRS_DLY);
    localparam logic [6:0] U_PRS = 7'(PRS_LEN);
    localparam logic [6:0] U_TX  = 7'(TX_LEN);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(DVN - 1);

    state_t         state, state_nxt;
    logic           s0, lin, lin_d;
    logic [DVW-1:0] div;
    logic [6:0]     u;
    logic [2:0]     cnt;
    logic [7:0]     tx_sh;
    logic [6:0]     rx_sh;
    logic           tx_busy, tx_end, drv;
    logic           fall, pls, u_rst, clr, tx_load, rx_bit;
    logic           ev_rst, ev_rx, ev_tx, ev_fin, drv_nxt;

    // Open-drain: only ever pull low; the async reset releases the line at once.
    assign onewire  = drv ? 1'b0 : 1'bz;

    assign fall     = lin_d & ~lin;
    assign pls      = (div == DIV_LAST);
    assign u_rst    = (u >= U_RST);
    assign rx_bit   = (u < U_SMP);
    assign tx_ready = ~tx_busy & (state == IDLE);
    assign tx_load  = tx_valid & tx_ready;
    // The unit timer restarts on every state change except TXD->WAITH, where the
    // low time keeps counting from the master's falling edge for reset detection.
    assign clr      = (state_nxt != state) && (state != TXD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (fall) state_nxt = (tx_busy && !tx_sh[0]) ? TXD : LOW;
            LOW, WAITH: if (lin)  state_nxt = u_rst ? PRSW : IDLE;
            TXD:        if (u >= U_TX) state_nxt = WAITH;
            PRSW: begin
                if (!lin)               state_nxt = LOW;
                else if (u >= U_DLY)    state_nxt = PRSD;
            end
            PRSD:       if (u >= U_PRS) state_nxt = WAITH;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ev_rst  = 1'b0;
        ev_rx   = 1'b0;
        ev_tx   = 1'b0;
        ev_fin  = 1'b0;
        case (state)
            LOW: begin
                if (lin) begin
                    if (u_rst) begin
                        ev_rst = 1'b1;
                    end else if (tx_busy) begin
                        ev_tx  = 1'b1;
                        ev_fin = (cnt == 3'd7);
                    end else begin
                        ev_rx  = 1'b1;
                    end
                end
            end
            TXD:   if (u >= U_TX) ev_tx = 1'b1;
            WAITH: begin
                if (lin) begin
                    if (u_rst) ev_rst = 1'b1;
                    else       ev_fin = tx_end;
                end
            end
            default: ;
        endcase
        drv_nxt = (state_nxt == TXD) || (state_nxt == PRSD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0       <= 1'b1;
            lin      <= 1'b1;
            lin_d    <= 1'b1;
            div      <= '0;
            u        <= '0;
            cnt      <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            tx_busy  <= 1'b0;
            tx_end   <= 1'b0;
            drv      <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
            rst_det  <= 1'b0;
        end else begin
            s0       <= onewire;
            lin      <= s0;
            lin_d    <= lin;
            drv      <= drv_nxt;
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
            rst_det  <= 1'b0;

            if (clr) begin
                div <= '0;
                u   <= '0;
            end else if (state != IDLE) begin
                div <= pls ? '0 : div + 1'b1;
                if (pls && u != 7'd127) u <= u + 7'd1;
            end

            if (tx_load) begin
                tx_busy <= 1'b1;
                tx_sh   <= tx_data;
                cnt     <= '0;
                tx_end  <= 1'b0;
            end
            if (ev_rst) begin
                rst_det <= 1'b1;
                tx_busy <= 1'b0;
                tx_end  <= 1'b0;
                cnt     <= '0;
                rx_sh   <= '0;
            end
            if (ev_rx) begin
                rx_sh <= {rx_bit, rx_sh[6:1]};
                cnt   <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    rx_data  <= {rx_bit, rx_sh};
                    rx_valid <= 1'b1;
                end
            end
            if (ev_tx) begin
                tx_sh <= {1'b0, tx_sh[7:1]};
                cnt   <= cnt + 3'd1;
                if (state == TXD && cnt == 3'd7) tx_end <= 1'b1;
            end
            if (ev_fin) begin
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
                tx_end  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_onewire_slave.sv
// Directed bench: a behavioural 1-wire master on a pulled-up bus exercises the responder.
module tb_onewire_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mdrv = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, rx_valid, rst_det;
    logic [7:0] rx_data;
    wire        onewire;

    int tests = 0;
    int fails = 0;
    int rxv_cnt = 0, txd_cnt = 0, rst_cnt = 0, slv_low = 0;
    logic [7:0] rx_last = 8'h00;

    pullup (onewire);
    assign onewire = mdrv ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    onewire_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .onewire  (onewire),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rst_det  (rst_det)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_last = rx_data;
        end
        if (tx_done) txd_cnt++;
        if (rst_det) rst_cnt++;
        if (!mdrv && onewire === 1'b0) slv_low++;
    end

    task automatic wait_units(input int n);
        repeat (2 * n) @(posedge clk);
        #1;
    endtask

    task automatic write_bit(input logic b);
        mdrv = 1'b1;
        wait_units(b ? 1 : 10);
        mdrv = 1'b0;
        wait_units(15);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic read_bit(output logic b);
        mdrv = 1'b1;
        wait_units(1);
        mdrv = 1'b0;
        wait_units(2);
        b = (onewire === 1'b0) ? 1'b0 : 1'b1;
        wait_units(13);
    endtask

    task automatic test_reset();
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        tests++; if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_tx_done got %b want 0", tx_done); end
        tests++; if (rst_det !== 1'b0) begin fails++; $display("FAIL reset_rst_det got %b want 0", rst_det); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
        tests++; if (onewire !== 1'b1) begin fails++; $display("FAIL reset_bus got %b want 1", onewire); end
    endtask

    task automatic test_write_byte();
        int b_rx = rxv_cnt, b_low = slv_low, b_rst = rst_cnt;
        write_byte(8'hA5);
        tests++; if (rxv_cnt - b_rx !== 1) begin fails++; $display("FAIL wr_rx_valid_count got %0d want 1", rxv_cnt - b_rx); end
        tests++; if (rx_last !== 8'hA5) begin fails++; $display("FAIL wr_rx_data got %h want a5", rx_last); end
        tests++; if (slv_low - b_low !== 0) begin fails++; $display("FAIL wr_slave_drive got %0d want 0", slv_low - b_low); end
        tests++; if (rst_cnt - b_rst !== 0) begin fails++; $display("FAIL wr_rst_det got %0d want 0", rst_cnt - b_rst); end
    endtask

    task automatic test_presence();
        int b_rst = rst_cnt, b_low = slv_low, d;
        mdrv = 1'b1;
        wait_units(80);
        tests++; if (rst_cnt - b_rst !== 0) begin fails++; $display("FAIL prs_early_rst_det got %0d want 0", rst_cnt - b_rst); end
        mdrv = 1'b0;
        wait_units(6);
        tests++; if (onewire !== 1'b0) begin fails++; $display("FAIL prs_sample got %b want 0", onewire); end
        wait_units(30);
        d = slv_low - b_low;
        tests++; if (rst_cnt - b_rst !== 1) begin fails++; $display("FAIL prs_rst_det got %0d want 1", rst_cnt - b_rst); end
        tests++; if (d < 30 || d > 36) begin fails++; $display("FAIL prs_length got %0d clocks want 30..36", d); end
        tests++; if (onewire !== 1'b1) begin fails++; $display("FAIL prs_release got %b want 1", onewire); end
    endtask

    task automatic test_read_byte();
        int b_txd = txd_cnt, b_rx = rxv_cnt;
        logic [7:0] got;
        logic b;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rd_ready_before got %b want 1", tx_ready); end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL rd_ready_after_load got %b want 0", tx_ready); end
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            got[i] = b;
        end
        tests++; if (got !== 8'h3C) begin fails++; $display("FAIL rd_data got %h want 3c", got); end
        tests++; if (txd_cnt - b_txd !== 1) begin fails++; $display("FAIL rd_tx_done got %0d want 1", txd_cnt - b_txd); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rd_ready_end got %b want 1", tx_ready); end
        tests++; if (rxv_cnt - b_rx !== 0) begin fails++; $display("FAIL rd_rx_valid got %0d want 0", rxv_cnt - b_rx); end
    endtask

    task automatic test_reset_mid_byte();
        int b_rx = rxv_cnt, b_rst = rst_cnt;
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        mdrv = 1'b1;
        wait_units(80);
        mdrv = 1'b0;
        wait_units(40);
        tests++; if (rxv_cnt - b_rx !== 0) begin fails++; $display("FAIL mid_no_rx_valid got %0d want 0", rxv_cnt - b_rx); end
        write_byte(8'h0F);
        tests++; if (rxv_cnt - b_rx !== 1) begin fails++; $display("FAIL mid_rx_valid got %0d want 1", rxv_cnt - b_rx); end
        tests++; if (rx_last !== 8'h0F) begin fails++; $display("FAIL mid_rx_data got %h want 0f", rx_last); end
        tests++; if (rst_cnt - b_rst !== 1) begin fails++; $display("FAIL mid_rst_det got %0d want 1", rst_cnt - b_rst); end
    endtask

    task automatic test_load_hold();
        int seen = 0;
        mdrv = 1'b1;
        wait_units(3);
        tx_data  = 8'hFE;
        tx_valid = 1'b1;
        wait_units(3);
        tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL hold_ready_in_low got %b want 0", tx_ready); end
        mdrv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_ready) seen++;
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tests++; if (seen !== 1) begin fails++; $display("FAIL hold_ready_cycles got %0d want 1", seen); end
        wait_units(15);
        tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL hold_loaded_busy got %b want 0", tx_ready); end
    endtask

    task automatic test_txd_hold();
        int b_rst = rst_cnt, b_txd = txd_cnt, b_low = slv_low, d;
        mdrv = 1'b1;
        wait_units(60);
        mdrv = 1'b0;
        wait_units(6);
        tests++; if (onewire !== 1'b0) begin fails++; $display("FAIL txdh_presence got %b want 0", onewire); end
        wait_units(30);
        d = slv_low - b_low;
        tests++; if (rst_cnt - b_rst !== 1) begin fails++; $display("FAIL txdh_rst_det got %0d want 1", rst_cnt - b_rst); end
        tests++; if (txd_cnt - b_txd !== 0) begin fails++; $display("FAIL txdh_tx_done got %0d want 0", txd_cnt - b_txd); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL txdh_ready got %b want 1", tx_ready); end
        tests++; if (d < 30 || d > 36) begin fails++; $display("FAIL txdh_presence_len got %0d clocks want 30..36", d); end
    endtask

    task automatic test_async_reset();
        mdrv = 1'b1;
        wait_units(80);
        mdrv = 1'b0;
        wait_units(6);
        tests++; if (onewire !== 1'b0) begin fails++; $display("FAIL arst_driving got %b want 0", onewire); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (onewire !== 1'b1) begin fails++; $display("FAIL arst_release got %b want 1", onewire); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_units(2);
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL arst_ready got %b want 1", tx_ready); end
        tests++; if (onewire !== 1'b1) begin fails++; $display("FAIL arst_bus_idle got %b want 1", onewire); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_units(2);
        test_reset();
        test_write_byte();
        test_presence();
        test_read_byte();
        test_reset_mid_byte();
        test_load_hold();
        test_txd_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
